// File: rtl/dt1_mem_arbiter_if.sv
// Bus bundle for the fetch/data to memory arbiter: fetch port, data port, memory port and stalls.
// The slave modport is the arbiter's view; the master modport is the view of the pipeline and memory around it.
interface dt1_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_dm;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_rdata, if_ready,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_ready,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall_if, stall_dm
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_rdata, if_ready,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_ready,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall_if, stall_dm
    );
endinterface

// File: rtl/dt1_mem_arbiter.sv
// Single-outstanding memory arbiter between instruction fetch and data ports.
// Data has priority; a fetch starved for STARVE_MAX consecutive data grants wins the next arbitration.
module dt1_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    dt1_mem_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int unsigned     CW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_killed;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rsp;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_dm_rdata;
    logic [CW-1:0] r_cnt;

    logic w_any_req;
    logic w_pick_if;
    logic w_if_done;
    logic w_dm_done;

    assign w_any_req = bus.if_req | bus.dm_req;
    assign w_pick_if = bus.if_req & (~bus.dm_req | (r_cnt == CNT_MAX));
    // A kill arriving in DONE must still mask the completion, so fetch data is held in r_rsp until committed.
    assign w_if_done = (r_state == S_DONE) & (r_owner == OWN_IF) & ~r_killed & ~bus.if_kill;
    assign w_dm_done = (r_state == S_DONE) & (r_owner == OWN_DM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= OWN_IF;
            r_killed   <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp      <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_killed <= 1'b0;
                        r_state  <= S_REQ;
                        if (w_pick_if) begin
                            r_owner <= OWN_IF;
                            r_addr  <= bus.if_addr;
                            r_we    <= 1'b0;
                            r_be    <= '0;
                            r_wdata <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_owner <= OWN_DM;
                            r_addr  <= bus.dm_addr;
                            r_we    <= bus.dm_we;
                            r_be    <= bus.dm_be;
                            r_wdata <= bus.dm_wdata;
                            // Data only wins at CNT_MAX when no fetch waits, so the increment saturates by itself.
                            r_cnt   <= bus.if_req ? r_cnt + 1'b1 : '0;
                        end
                    end
                end
                S_REQ: begin
                    if ((r_owner == OWN_IF) && bus.if_kill) begin
                        r_killed <= 1'b1;
                        r_state  <= bus.mem_gnt ? S_WAIT : S_IDLE;
                    end else if (bus.mem_gnt) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if ((r_owner == OWN_IF) && bus.if_kill) begin
                        r_killed <= 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        r_state <= S_DONE;
                        if (r_owner == OWN_IF) begin
                            r_rsp <= bus.mem_rdata;
                        end else if (!r_we) begin
                            r_dm_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    if (w_if_done) begin
                        r_if_rdata <= r_rsp;
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = (r_state == S_REQ);
    assign bus.mem_we    = r_we;
    assign bus.mem_be    = r_be;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.if_ready  = w_if_done;
    assign bus.if_rdata  = w_if_done ? r_rsp : r_if_rdata;
    assign bus.dm_ready  = w_dm_done;
    assign bus.dm_rdata  = r_dm_rdata;

    assign bus.stall_if  = bus.if_req & ~bus.if_ready & ~bus.if_kill;
    assign bus.stall_dm  = bus.dm_req & ~bus.dm_ready;

endmodule

// File: doc/dt1_mem_arbiter.md
DT1_MEM_ARBITER -- requirements
Module: dt1_mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the number of consecutive data grants allowed while a fetch waits.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 if_req  in  1  SHALL be the fetch request; it is held until if_ready or if_kill.
REQ-005 if_addr  in  32  SHALL be the fetch address, stable while if_req is high.
REQ-006 if_kill  in  1  SHALL cancel the outstanding fetch (branch taken).
REQ-007 if_rdata  out  32  SHALL be the registered fetched word.
REQ-008 if_ready  out  1  SHALL be a one-cycle completion pulse for fetch.
REQ-009 dm_req, dm_we (1), dm_be (4), dm_addr (32), dm_wdata (32)  in  SHALL form the data-side request, all stable while dm_req is high.
REQ-010 dm_rdata  out  32  SHALL be the registered load data.
REQ-011 dm_ready  out  1  SHALL be a one-cycle completion pulse for data.
REQ-012 mem_req, mem_we (1), mem_be (4), mem_addr (32), mem_wdata (32)  out  SHALL form the memory-side request.
REQ-013 mem_gnt  in  1  SHALL accept a request in the cycle where mem_req and mem_gnt are both high.
REQ-014 mem_rvalid  in  1 and mem_rdata  in  32  SHALL return the response; rvalid also acknowledges writes.
REQ-015 stall_if, stall_dm  out  1  SHALL be the pipeline stall indications.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT and DONE, and SHALL keep at most one transaction outstanding.
REQ-017 IDLE: if any request is present, the arbiter SHALL latch the owner, address, we, be and wdata into registers and go to REQ; otherwise it SHALL stay in IDLE.
REQ-018 Priority: data SHALL win over fetch, except when the starvation counter equals STARVE_MAX and if_req is high, in which case fetch SHALL win.
REQ-019 Starvation counter: it SHALL increment on a data grant taken while if_req is high, and SHALL clear on a fetch grant or on a data grant taken while if_req is low; it SHALL saturate at STARVE_MAX.
REQ-020 REQ: mem_req SHALL be 1 and the mem_* outputs SHALL be driven from the latched registers; on mem_gnt the FSM SHALL go to WAIT.
REQ-021 WAIT: mem_req SHALL be 0; on mem_rvalid the arbiter SHALL capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
REQ-022 DONE: the owner's ready SHALL be 1 for exactly this cycle, then the FSM SHALL return to IDLE; no arbitration SHALL occur in DONE.
REQ-023 Minimum latency: request at cycle N with mem_gnt and mem_rvalid both immediate -> ready at cycle N+3.
REQ-024 A write SHALL leave dm_rdata unchanged; mem_we and mem_be SHALL be 0 for fetches.
REQ-025 if_kill in REQ with fetch owner: mem_req SHALL drop in the next cycle, the FSM SHALL return to IDLE, and no if_ready SHALL be issued.
REQ-026 if_kill in WAIT or DONE with fetch owner: the transaction SHALL complete, and if_ready and the if_rdata update SHALL be suppressed.
REQ-027 if_kill SHALL have no effect on a data-owned transaction or in IDLE.
REQ-028 if_kill and mem_gnt in the same REQ cycle: kill SHALL take priority; the granted response SHALL be waited for and discarded.
REQ-029 mem_rvalid outside WAIT SHALL be ignored.
REQ-030 stall_if SHALL equal if_req & ~if_ready & ~if_kill; stall_dm SHALL equal dm_req & ~dm_ready (combinational).

Reset
REQ-031 On rst, the FSM SHALL go to IDLE immediately, and the counter, owner, latched registers, if_rdata, dm_rdata, if_ready, dm_ready and mem_req SHALL all be 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-033 Single fetch: if_req=1, if_addr=0x100, gnt and rvalid immediate, mem_rdata=0x00500093 -> mem_addr=0x100 at N+1, if_ready=1 with if_rdata=0x00500093 at N+3.
REQ-034 Simultaneous requests: if_req and dm_req both 1 (dm_addr=0x2000, we=1, be=0xF, wdata=0xDEADBEEF) -> data is issued first; fetch completes after dm_ready; dm_rdata is unchanged.
REQ-035 Starvation: dm_req held continuously with if_req=1 and STARVE_MAX=4 -> four data grants, then a fetch grant on the fifth, then the counter is 0.
REQ-036 Kill: if_kill pulsed in REQ (gnt=0) -> mem_req=0 next cycle and no if_ready; pulsed in WAIT -> rvalid consumed and if_ready stays 0.
REQ-037 Backpressure: mem_gnt held 0 for 5 cycles -> mem_req and mem_addr are stable throughout, and stall_dm=1 until dm_ready.
REQ-038 Reset asserted in WAIT -> all outputs are 0 asynchronously; an rvalid after release produces no ready.
